// File: rtl/alu_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_request_sequencer
// Description : Accepts ALU requests over a valid/ready handshake, launches
//               the multi-cycle ALU control unit with a one-cycle start
//               pulse, waits for completion or timeout, and returns the
//               result, error code and cycle count over a response handshake.
//               Divide-by-zero is detected up front and never reaches the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_request_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 alu_start,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic                 alu_finish,
  input  logic [WIDTH-1:0]     alu_result_hi,
  input  logic [WIDTH-1:0]     alu_result_lo,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic [1:0]           rsp_op,
  output logic [1:0]           rsp_err,
  output logic [6:0]           rsp_cycles
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_BUSY   = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  localparam logic [1:0] c_OP_DIV = 2'b00;

  localparam logic [1:0] c_ERR_OK   = 2'b00;
  localparam logic [1:0] c_ERR_DIV0 = 2'b01;
  localparam logic [1:0] c_ERR_TMO  = 2'b10;

  // Counter value seen in the last permitted BUSY cycle, and the cycle count
  // reported when that cycle passes without a finish strobe.
  localparam logic [6:0] c_TMO_LAST = 7'(TIMEOUT - 1);
  localparam logic [6:0] c_TMO_CYC  = 7'(TIMEOUT);
  localparam logic [6:0] c_CNT_MAX  = 7'h7F;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [6:0]         r_count;
  logic [6:0]         w_count_inc;
  logic [1:0]         r_alu_op;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2*WIDTH-1:0] r_rsp_result;
  logic [1:0]         r_rsp_op;
  logic [1:0]         r_rsp_err;
  logic [6:0]         r_rsp_cycles;
  logic               w_accept;
  logic               w_div0;
  logic               w_finish;
  logic               w_timeout;

  assign req_ready  = (r_state == c_IDLE);
  assign alu_start  = (r_state == c_LAUNCH);
  assign rsp_valid  = (r_state == c_RESP);
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign rsp_err    = r_rsp_err;
  assign rsp_cycles = r_rsp_cycles;

  assign w_count_inc = (r_count == c_CNT_MAX) ? c_CNT_MAX : r_count + 7'd1;

  // Event decode and next-state selection; finish beats timeout in BUSY.
  always_comb begin
    w_accept    = req_valid && (r_state == c_IDLE);
    w_div0      = w_accept && (req_op == c_OP_DIV) && (req_b == '0);
    w_finish    = (r_state == c_BUSY) && alu_finish;
    w_timeout   = (r_state == c_BUSY) && !alu_finish && (r_count == c_TMO_LAST);
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_div0) begin
          w_state_nxt = c_RESP;
        end else if (w_accept) begin
          w_state_nxt = c_LAUNCH;
        end
      end
      c_LAUNCH: w_state_nxt = c_BUSY;
      c_BUSY: begin
        if (w_finish || w_timeout) begin
          w_state_nxt = c_RESP;
        end
      end
      c_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch: captured on acceptance, held stable until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else if (w_accept) begin
      r_alu_op <= req_op;
      r_alu_a  <= req_a;
      r_alu_b  <= req_b;
    end
  end

  // Cycle counter: cleared while launching, counts up (saturating) while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (r_state == c_LAUNCH) begin
      r_count <= '0;
    end else if ((r_state == c_BUSY) && !w_finish && !w_timeout) begin
      r_count <= w_count_inc;
    end
  end

  // Response registers: loaded on entry to RESP only, so they stay frozen
  // for however long the consumer applies backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= '0;
      r_rsp_cycles <= '0;
    end else if (w_div0) begin
      r_rsp_result <= '1;
      r_rsp_op     <= req_op;
      r_rsp_err    <= c_ERR_DIV0;
      r_rsp_cycles <= '0;
    end else if (w_finish) begin
      r_rsp_result <= {alu_result_hi, alu_result_lo};
      r_rsp_op     <= r_alu_op;
      r_rsp_err    <= c_ERR_OK;
      r_rsp_cycles <= w_count_inc;
    end else if (w_timeout) begin
      r_rsp_result <= '0;
      r_rsp_op     <= r_alu_op;
      r_rsp_err    <= c_ERR_TMO;
      r_rsp_cycles <= c_TMO_CYC;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_request_sequencer
// Description : Directed self-checking bench for alu_request_sequencer with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_request_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_finish;
  logic [7:0]  alu_result_hi;
  logic [7:0]  alu_result_lo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_op;
  logic [1:0]  rsp_err;
  logic [6:0]  rsp_cycles;

  int n_checks;
  int n_fails;
  int n_start;
  int k;
  int bad;

  alu_request_sequencer #(.WIDTH(8), .TIMEOUT(64)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_start    (alu_start),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_finish   (alu_finish),
    .alu_result_hi(alu_result_hi),
    .alu_result_lo(alu_result_lo),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_op       (rsp_op),
    .rsp_err      (rsp_err),
    .rsp_cycles   (rsp_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses, sampled mid-cycle.
  always @(negedge clk) if (alu_start === 1'b1) n_start++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fails = 0; n_start = 0;
    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00;
    alu_finish = 1'b0; alu_result_hi = 8'h00; alu_result_lo = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_outputs", {rsp_result, rsp_op, rsp_err, rsp_cycles, alu_op}, 32'd0);
    rst = 1'b1;
    tick();

    // ADD 5+3, finish 4 cycles after start.
    send(2'b10, 8'h05, 8'h03);
    check("add_start", 32'(alu_start), 32'd1);
    check("add_operands", {22'd0, alu_op, alu_a, alu_b} & 32'h3FFFF, {14'd0, 2'b10, 8'h05, 8'h03});
    check("add_req_ready_lo", 32'(req_ready), 32'd0);
    tick();
    check("add_start_one_cycle", 32'(alu_start), 32'd0);
    tick(); tick(); tick();
    alu_finish = 1'b1; alu_result_hi = 8'h00; alu_result_lo = 8'h08;
    tick();
    alu_finish = 1'b0;
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'h0008);
    check("add_err", 32'(rsp_err), 32'd0);
    check("add_cycles", 32'(rsp_cycles), 32'd4);
    check("add_rsp_op", 32'(rsp_op), 32'd2);
    consume();
    check("add_back_idle", 32'(req_ready), 32'd1);
    check("add_start_count", 32'(n_start), 32'd1);

    // Divide by zero bypasses the ALU.
    send(2'b00, 8'h10, 8'h00);
    check("div0_no_start", 32'(alu_start), 32'd0);
    check("div0_rsp_valid", 32'(rsp_valid), 32'd1);
    check("div0_result", 32'(rsp_result), 32'hFFFF);
    check("div0_err", 32'(rsp_err), 32'd1);
    check("div0_cycles", 32'(rsp_cycles), 32'd0);
    consume();
    check("div0_start_count", 32'(n_start), 32'd1);

    // Timeout: MUL never finishes.
    send(2'b01, 8'h03, 8'h04);
    k = 0;
    do begin tick(); k++; end while (!rsp_valid && k < 200);
    check("tmo_latency", 32'(k), 32'd65);
    check("tmo_err", 32'(rsp_err), 32'd2);
    check("tmo_result", 32'(rsp_result), 32'h0000);
    check("tmo_cycles", 32'(rsp_cycles), 32'd64);
    consume();

    // Backpressure: MUL 7*6, response held while a new request waits.
    send(2'b01, 8'h07, 8'h06);
    tick();
    alu_finish = 1'b1; alu_result_hi = 8'h00; alu_result_lo = 8'h2A;
    tick();
    alu_finish = 1'b0; alu_result_lo = 8'hEE;
    check("bp_result", 32'(rsp_result), 32'h002A);
    check("bp_cycles", 32'(rsp_cycles), 32'd1);
    req_valid = 1'b1; req_op = 2'b10; req_a = 8'h01; req_b = 8'h02;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h002A || req_ready !== 1'b0 || alu_start !== 1'b0) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_no_accept_on_consume", {30'd0, req_ready, alu_start}, 32'b10);
    tick();
    req_valid = 1'b0;
    check("bp_second_accept", {23'd0, alu_start, alu_a}, {23'd0, 1'b1, 8'h01});
    tick();
    alu_finish = 1'b1; alu_result_hi = 8'h00; alu_result_lo = 8'h03;
    tick();
    alu_finish = 1'b0;
    check("bp_second_result", 32'(rsp_result), 32'h0003);
    consume();

    // Reset mid-BUSY, then a stray finish in IDLE.
    send(2'b11, 8'h09, 8'h02);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rstb_async_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
    check("rstb_outputs", {alu_a, alu_b, alu_op, alu_start, 13'd0}, 32'd0);
    tick();
    rst = 1'b1;
    alu_finish = 1'b1; alu_result_hi = 8'h55; alu_result_lo = 8'hAA;
    tick();
    alu_finish = 1'b0;
    check("stray_no_rsp", {30'd0, rsp_valid, req_ready}, 32'b01);
    check("stray_outputs", {rsp_result, rsp_err, rsp_cycles, 7'd0}, 32'd0);
    check("rstb_start_count", 32'(n_start), 32'd5);

    // Finish in the same cycle as the timeout boundary wins.
    send(2'b10, 8'h01, 8'h01);
    repeat (64) tick();
    alu_finish = 1'b1; alu_result_hi = 8'h12; alu_result_lo = 8'h34;
    tick();
    alu_finish = 1'b0;
    check("coinc_rsp_valid", 32'(rsp_valid), 32'd1);
    check("coinc_err", 32'(rsp_err), 32'd0);
    check("coinc_result", 32'(rsp_result), 32'h1234);
    check("coinc_cycles", 32'(rsp_cycles), 32'd64);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
